// File: rtl/ap_handshake_profiler.sv
// ap_handshake_profiler: per-channel ap_start/ap_done/ap_continue transaction profiler
// with saturating counters and a registered read port. Rev 1.0
`default_nettype none

module ap_handshake_profiler #(
  parameter int N_CH   = 3,
  parameter int CNT_W  = 32,
  parameter int ADDR_W = $clog2(N_CH) + 3
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              clear,
  input  logic [N_CH-1:0]   ap_start,
  input  logic [N_CH-1:0]   ap_ready,
  input  logic [N_CH-1:0]   ap_done,
  input  logic [N_CH-1:0]   ap_continue,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [CNT_W-1:0]  rd_data,
  output logic              rd_valid,
  output logic [N_CH-1:0]   busy,
  output logic [N_CH-1:0]   sat
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_RUN       = 2'd1,
    S_DONE_WAIT = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] C_ONES = '1;

  function automatic logic [CNT_W-1:0] inc_sat(input logic [CNT_W-1:0] v);
    return (v == C_ONES) ? v : v + CNT_W'(1);
  endfunction

  logic [N_CH-1:0][CNT_W-1:0] txn_w, acc_w, last_w, max_w, min_w, stall_w;
  logic [N_CH-1:0][1:0]       state_w;
  logic [N_CH-1:0]            sat_w;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    state_e           state_q, state_d;
    logic [CNT_W-1:0] lat_q, lat_d;
    logic [CNT_W-1:0] txn_q, txn_d, acc_q, acc_d, last_q, last_d;
    logic [CNT_W-1:0] max_q, max_d, min_q, min_d, stall_q, stall_d;
    logic             sat_q, sat_d, busy_q, busy_d;
    logic             commit, stall_en;
    logic [CNT_W-1:0] commit_lat;

    always_comb begin
      state_d    = state_q;
      lat_d      = lat_q;
      txn_d      = txn_q;
      acc_d      = acc_q;
      last_d     = last_q;
      max_d      = max_q;
      min_d      = min_q;
      stall_d    = stall_q;
      sat_d      = sat_q;
      commit     = 1'b0;
      commit_lat = '0;
      stall_en   = 1'b0;

      // Accepts are counted regardless of FSM state so pipelined cores are covered.
      if (ap_start[i] && ap_ready[i]) begin
        acc_d = inc_sat(acc_q);
        if (acc_q == C_ONES) sat_d = 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (ap_start[i]) begin
            if (!ap_done[i]) begin
              state_d = S_RUN;
              lat_d   = CNT_W'(1);
            end else if (ap_continue[i]) begin
              commit     = 1'b1;
              commit_lat = '0;
            end else begin
              state_d  = S_DONE_WAIT;
              lat_d    = '0;
              stall_en = 1'b1;
            end
          end
        end
        S_RUN: begin
          if (!ap_done[i]) begin
            lat_d = inc_sat(lat_q);
            if (lat_q == C_ONES) sat_d = 1'b1;
          end else if (ap_continue[i]) begin
            commit     = 1'b1;
            commit_lat = lat_q;
            state_d    = S_IDLE;
          end else begin
            state_d  = S_DONE_WAIT;
            stall_en = 1'b1;
          end
        end
        S_DONE_WAIT: begin
          if (ap_continue[i]) begin
            commit     = 1'b1;
            commit_lat = lat_q;
            state_d    = S_IDLE;
          end else begin
            stall_en = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase

      if (stall_en) begin
        stall_d = inc_sat(stall_q);
        if (stall_q == C_ONES) sat_d = 1'b1;
      end

      if (commit) begin
        txn_d  = inc_sat(txn_q);
        if (txn_q == C_ONES) sat_d = 1'b1;
        last_d = commit_lat;
        if (commit_lat > max_q) max_d = commit_lat;
        if (commit_lat < min_q) min_d = commit_lat;
      end

      busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        state_q <= S_IDLE;
        lat_q   <= '0;
        txn_q   <= '0;
        acc_q   <= '0;
        last_q  <= '0;
        max_q   <= '0;
        min_q   <= C_ONES;
        stall_q <= '0;
        sat_q   <= 1'b0;
        busy_q  <= 1'b0;
      end else if (clear) begin
        state_q <= S_IDLE;
        lat_q   <= '0;
        txn_q   <= '0;
        acc_q   <= '0;
        last_q  <= '0;
        max_q   <= '0;
        min_q   <= C_ONES;
        stall_q <= '0;
        sat_q   <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        lat_q   <= lat_d;
        txn_q   <= txn_d;
        acc_q   <= acc_d;
        last_q  <= last_d;
        max_q   <= max_d;
        min_q   <= min_d;
        stall_q <= stall_d;
        sat_q   <= sat_d;
        busy_q  <= busy_d;
      end
    end

    assign txn_w[i]   = txn_q;
    assign acc_w[i]   = acc_q;
    assign last_w[i]  = last_q;
    assign max_w[i]   = max_q;
    assign min_w[i]   = min_q;
    assign stall_w[i] = stall_q;
    assign state_w[i] = state_q;
    assign sat_w[i]   = sat_q;
    assign busy[i]    = busy_q;
    assign sat[i]     = sat_q;
  end

  logic [ADDR_W-1:0] rd_ch;
  logic [CNT_W-1:0]  rd_data_d, rd_data_q;
  logic              rd_valid_q;

  assign rd_ch = rd_addr >> 3;

  // Channels at or above N_CH match no entry and read as zero.
  always_comb begin
    rd_data_d = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (rd_ch == ADDR_W'(c)) begin
        case (rd_addr[2:0])
          3'd0: rd_data_d = txn_w[c];
          3'd1: rd_data_d = acc_w[c];
          3'd2: rd_data_d = last_w[c];
          3'd3: rd_data_d = max_w[c];
          3'd4: rd_data_d = min_w[c];
          3'd5: rd_data_d = stall_w[c];
          3'd6: rd_data_d = {{(CNT_W-3){1'b0}}, sat_w[c], state_w[c]};
          3'd7: rd_data_d = CNT_W'(N_CH);
        endcase
      end
    end
  end

  // A read coinciding with clear still returns the pre-clear snapshot.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else if (rd_en) begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= 1'b1;
    end else if (clear) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_ap_handshake_profiler.sv
// tb_ap_handshake_profiler: directed self-checking bench for ap_handshake_profiler.
`default_nettype none

module tb_ap_handshake_profiler;

  localparam int N_CH   = 3;
  localparam int CNT_W  = 32;
  localparam int ADDR_W = $clog2(N_CH) + 3;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              clear = 1'b0;
  logic [N_CH-1:0]   ap_start = '0;
  logic [N_CH-1:0]   ap_ready = '0;
  logic [N_CH-1:0]   ap_done = '0;
  logic [N_CH-1:0]   ap_continue = '1;
  logic              rd_en = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic [CNT_W-1:0]  rd_data;
  logic              rd_valid;
  logic [N_CH-1:0]   busy;
  logic [N_CH-1:0]   sat;

  logic       s8_clear = 1'b0;
  logic [0:0] s8_start = '0;
  logic [0:0] s8_ready = '0;
  logic [0:0] s8_done = '0;
  logic [0:0] s8_cont = '1;
  logic       s8_rd_en = 1'b0;
  logic [2:0] s8_rd_addr = '0;
  logic [7:0] s8_rd_data;
  logic       s8_rd_valid;
  logic [0:0] s8_busy;
  logic [0:0] s8_sat;

  ap_handshake_profiler #(.N_CH(N_CH), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset_n(reset_n), .clear(clear),
    .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_continue(ap_continue),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .busy(busy), .sat(sat)
  );

  ap_handshake_profiler #(.N_CH(1), .CNT_W(8)) dut8 (
    .clock(clock), .reset_n(reset_n), .clear(s8_clear),
    .ap_start(s8_start), .ap_ready(s8_ready), .ap_done(s8_done), .ap_continue(s8_cont),
    .rd_en(s8_rd_en), .rd_addr(s8_rd_addr), .rd_data(s8_rd_data), .rd_valid(s8_rd_valid),
    .busy(s8_busy), .sat(s8_sat)
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic rd_chk(input string tag, input int ch, input int sel, input logic [31:0] exp);
    rd_en   = 1'b1;
    rd_addr = ADDR_W'((ch << 3) | sel);
    tick();
    rd_en = 1'b0;
    chk(tag, rd_data, exp);
  endtask

  task automatic rd8_chk(input string tag, input int sel, input logic [31:0] exp);
    s8_rd_en   = 1'b1;
    s8_rd_addr = 3'(sel);
    tick();
    s8_rd_en = 1'b0;
    chk(tag, {24'd0, s8_rd_data}, exp);
  endtask

  task automatic run_txn(input int ch, input int lat);
    if (lat == 0) begin
      ap_start[ch] = 1'b1;
      ap_done[ch]  = 1'b1;
      tick();
      ap_start[ch] = 1'b0;
      ap_done[ch]  = 1'b0;
    end else begin
      ap_start[ch] = 1'b1;
      tick();
      ap_start[ch] = 1'b0;
      repeat (lat - 1) tick();
      ap_done[ch] = 1'b1;
      tick();
      ap_done[ch] = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int busy_cnt;

    repeat (3) tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_sat", 32'(sat), 0);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_rd_data", rd_data, 0);
    reset_n = 1'b1;
    tick();

    rd_chk("rst_min_ch0", 0, 4, 32'hFFFF_FFFF);
    chk("rd_valid_hi", 32'(rd_valid), 1);
    rd_chk("rst_txn_ch0", 0, 0, 0);
    rd_chk("nch_const", 0, 7, 3);
    rd_chk("ch3_txn", 3, 0, 0);
    rd_chk("ch3_nch", 3, 7, 0);
    tick();
    chk("rd_valid_lo", 32'(rd_valid), 0);

    // 8-bit instance: accept counter saturation and clear
    s8_start = 1'b1;
    s8_ready = 1'b1;
    repeat (300) tick();
    s8_start = 1'b0;
    s8_ready = 1'b0;
    chk("s8_sat_set", 32'(s8_sat), 1);
    rd8_chk("s8_acc_sat", 1, 255);
    s8_clear = 1'b1;
    tick();
    s8_clear = 1'b0;
    chk("s8_sat_clr", 32'(s8_sat), 0);
    chk("s8_busy_clr", 32'(s8_busy), 0);
    rd8_chk("s8_acc_clr", 1, 0);
    rd8_chk("s8_min_clr", 4, 255);
    rd8_chk("s8_status_clr", 6, 0);

    // channel 0: latency 5, continue tied high
    busy_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      if (k == 0) ap_start[0] = 1'b1;
      if (k == 5) ap_done[0] = 1'b1;
      tick();
      ap_start[0] = 1'b0;
      ap_done[0]  = 1'b0;
      if (busy[0]) busy_cnt++;
    end
    chk("ch0_busy_cycles", 32'(busy_cnt), 5);
    rd_chk("ch0_txn", 0, 0, 1);
    rd_chk("ch0_last", 0, 2, 5);
    rd_chk("ch0_max", 0, 3, 5);
    rd_chk("ch0_min", 0, 4, 5);
    rd_chk("ch0_stall", 0, 5, 0);
    rd_chk("ch0_status", 0, 6, 0);
    rd_chk("ch0_acc", 0, 1, 0);

    // channel 1: latency 3, continue low for 4 cycles
    ap_continue[1] = 1'b0;
    ap_start[1] = 1'b1;
    tick();
    ap_start[1] = 1'b0;
    tick();
    tick();
    ap_done[1] = 1'b1;
    tick();
    ap_done[1] = 1'b0;
    chk("ch1_busy_wait", 32'(busy[1]), 1);
    rd_chk("ch1_status_wait", 1, 6, 2);
    tick();
    tick();
    ap_continue[1] = 1'b1;
    rd_chk("ch1_txn_pre", 1, 0, 0);
    chk("ch1_busy_done", 32'(busy[1]), 0);
    rd_chk("ch1_txn", 1, 0, 1);
    rd_chk("ch1_stall", 1, 5, 4);
    rd_chk("ch1_last", 1, 2, 3);

    // channel 2: zero latency then 3, 7, 2
    ap_ready[2] = 1'b1;
    run_txn(2, 0);
    ap_ready[2] = 1'b0;
    run_txn(2, 3);
    run_txn(2, 7);
    run_txn(2, 2);
    rd_chk("ch2_txn", 2, 0, 4);
    rd_chk("ch2_min", 2, 4, 0);
    rd_chk("ch2_max", 2, 3, 7);
    rd_chk("ch2_last", 2, 2, 2);
    rd_chk("ch2_acc", 2, 1, 1);

    // simultaneous zero-latency commits on all channels
    ap_start = '1;
    ap_done  = '1;
    tick();
    ap_start = '0;
    ap_done  = '0;
    rd_chk("all_txn_ch0", 0, 0, 2);
    rd_chk("all_txn_ch1", 1, 0, 2);
    rd_chk("all_txn_ch2", 2, 0, 5);
    rd_chk("all_min_ch0", 0, 4, 0);

    // asynchronous reset in the middle of a run
    ap_start[0] = 1'b1;
    tick();
    ap_start[0] = 1'b0;
    tick();
    chk("run_busy", 32'(busy[0]), 1);
    reset_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 0);
    tick();
    reset_n = 1'b1;
    ap_done[0] = 1'b1;
    tick();
    ap_done[0] = 1'b0;
    rd_chk("arst_txn_ch0", 0, 0, 0);
    rd_chk("arst_min_ch0", 0, 4, 32'hFFFF_FFFF);

    // clear together with a done and a read
    run_txn(2, 4);
    ap_start[0] = 1'b1;
    tick();
    ap_start[0] = 1'b0;
    tick();
    tick();
    ap_done[0] = 1'b1;
    clear      = 1'b1;
    rd_en      = 1'b1;
    rd_addr    = ADDR_W'(2 << 3);
    tick();
    ap_done[0] = 1'b0;
    clear      = 1'b0;
    rd_en      = 1'b0;
    chk("clr_rd_pre", rd_data, 1);
    chk("clr_rd_valid", 32'(rd_valid), 1);
    chk("clr_busy", 32'(busy), 0);
    rd_chk("clr_txn_ch0", 0, 0, 0);
    rd_chk("clr_last_ch0", 0, 2, 0);
    rd_chk("clr_txn_ch2", 2, 0, 0);
    rd_chk("clr_max_ch2", 2, 3, 0);
    rd_chk("clr_min_ch2", 2, 4, 32'hFFFF_FFFF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
